// File: rtl/flag_write_sched.sv
// -----------------------------------------------------------------------------
// flag_write_sched
//
// In-order scheduler for the NZCV status-flag register. Every flag-writing
// instruction (ALU S-form or MSR) gets a slot at issue. Slots are handed out
// in program order from a circular buffer. Flag writebacks may arrive out of
// order. Slots then commit to the architectural flag register strictly in
// order, at most one per cycle. Conditional (flag-reading) instructions are
// stalled until the youngest in-flight writer has its value. Once that value
// is present, they receive it by forwarding. A flush discards every in-flight
// slot.
//
// Handshake: issue is a valid/stall pair. An instruction presented with
// iss_valid_i=1 is accepted on a rising edge only if iss_stall_o=0 in that
// cycle. Writebacks are fire-and-forget pulses. They are accepted at the edge
// only if they target a busy, not-yet-done slot. Commits are single-cycle
// pulses on commit_s_o/commit_msr_o, and the flag register latches them at
// the same edge.
//
// Ports:
//   clk_i              clock, all state updates on the rising edge
//   rst_i              synchronous active-high reset
//   flush_i            synchronous discard of all in-flight slots
//   iss_valid_i        instruction presented at issue
//   iss_sets_flags_i   issuing instruction writes flags
//   iss_is_msr_i       flag writer is MSR (else ALU S-form)
//   iss_reads_flags_i  issuing instruction reads flags
//   iss_stall_o        hold issue this cycle
//   iss_tag_o          slot tag given to the issuing writer
//   rd_nzcv_o          flags seen by the issuing reader {N,Z,C,V}
//   arch_nzcv_i        current flag-register value {N,Z,C,V}
//   alu_wb_*_i         ALU flag writeback (valid, tag, nzcv)
//   msr_wb_*_i         MSR writeback (valid, tag, data[3:0])
//   commit_s_o         S-update strobe to the flag register
//   commit_msr_o       MSR-update strobe to the flag register
//   commit_nzcv_o      committed flag value (0 when nothing commits)
//   dbg_head_o         observability: oldest slot pointer
//   dbg_tail_o         observability: next slot to allocate
//   dbg_count_o        observability: number of in-flight slots
// -----------------------------------------------------------------------------
module flag_write_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             iss_valid_i,
    input  logic             iss_sets_flags_i,
    input  logic             iss_is_msr_i,
    input  logic             iss_reads_flags_i,
    output logic             iss_stall_o,
    output logic [TAG_W-1:0] iss_tag_o,
    output logic [3:0]       rd_nzcv_o,
    input  logic [3:0]       arch_nzcv_i,
    input  logic             alu_wb_valid_i,
    input  logic [TAG_W-1:0] alu_wb_tag_i,
    input  logic [3:0]       alu_wb_nzcv_i,
    input  logic             msr_wb_valid_i,
    input  logic [TAG_W-1:0] msr_wb_tag_i,
    input  logic [3:0]       msr_wb_data_i,
    output logic             commit_s_o,
    output logic             commit_msr_o,
    output logic [3:0]       commit_nzcv_o,
    output logic [TAG_W-1:0] dbg_head_o,
    output logic [TAG_W-1:0] dbg_tail_o,
    output logic [TAG_W:0]   dbg_count_o
);

    localparam logic [TAG_W:0] COUNT_FULL = (TAG_W+1)'(DEPTH);

    // Per-slot state
    logic       busy_q   [DEPTH];
    logic       done_q   [DEPTH];
    logic       is_msr_q [DEPTH];
    logic [3:0] nzcv_q   [DEPTH];
    logic       busy_d   [DEPTH];
    logic       done_d   [DEPTH];
    logic       is_msr_d [DEPTH];
    logic [3:0] nzcv_d   [DEPTH];

    // Global pointers
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic [TAG_W-1:0] youngest;
    logic             empty;
    logic             full;
    logic             flags_ready;
    logic             alloc;
    logic             cv;

    // The youngest in-flight writer sits just behind tail. Its value is what
    // a reader issuing now must see.
    assign youngest    = tail_q - TAG_W'(1);
    assign empty       = (count_q == '0);
    assign full        = (count_q == COUNT_FULL);
    assign flags_ready = empty | done_q[youngest];

    // A full buffer stalls on the current count. A commit in the same cycle
    // frees a slot only at the edge, so it does not release the stall.
    assign iss_stall_o = rst_i | flush_i |
                         (iss_valid_i & ((iss_sets_flags_i & full) |
                                         (iss_reads_flags_i & ~flags_ready)));

    assign alloc     = iss_valid_i & iss_sets_flags_i & ~iss_stall_o;
    assign iss_tag_o = tail_q;

    // A reader that also sets flags sees the state before its own allocation,
    // because this uses the pre-edge tail.
    assign rd_nzcv_o = empty ? arch_nzcv_i : nzcv_q[youngest];

    assign cv            = ~empty & done_q[head_q] & ~flush_i & ~rst_i;
    assign commit_s_o    = cv & ~is_msr_q[head_q];
    assign commit_msr_o  = cv &  is_msr_q[head_q];
    assign commit_nzcv_o = cv ? nzcv_q[head_q] : 4'b0000;

    assign dbg_head_o  = head_q;
    assign dbg_tail_o  = tail_q;
    assign dbg_count_o = count_q;

    // Next-state logic for the slots and pointers.
    // Allocation targets the tail and commit targets the head. These can only
    // alias when the buffer is empty (no commit) or full (no allocation), so
    // the two updates never collide on one slot. A writeback cannot hit the
    // committing slot, which is already done. It cannot hit the allocating
    // slot either, which is not yet busy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy_d[i]   = busy_q[i];
            done_d[i]   = done_q[i];
            is_msr_d[i] = is_msr_q[i];
            nzcv_d[i]   = nzcv_q[i];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // Writebacks: ALU has priority if both ports name the same slot.
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && !done_q[i]) begin
                if (alu_wb_valid_i && (alu_wb_tag_i == TAG_W'(i))) begin
                    done_d[i] = 1'b1;
                    nzcv_d[i] = alu_wb_nzcv_i;
                end else if (msr_wb_valid_i && (msr_wb_tag_i == TAG_W'(i))) begin
                    done_d[i] = 1'b1;
                    nzcv_d[i] = msr_wb_data_i;
                end
            end
        end

        if (alloc) begin
            busy_d[tail_q]   = 1'b1;
            done_d[tail_q]   = 1'b0;
            is_msr_d[tail_q] = iss_is_msr_i;
            nzcv_d[tail_q]   = 4'b0000;
            tail_d           = tail_q + TAG_W'(1);
        end

        if (cv) begin
            busy_d[head_q]   = 1'b0;
            done_d[head_q]   = 1'b0;
            is_msr_d[head_q] = 1'b0;
            nzcv_d[head_q]   = 4'b0000;
            head_d           = head_q + TAG_W'(1);
        end

        case ({alloc, cv})
            2'b10:   count_d = count_q + (TAG_W+1)'(1);
            2'b01:   count_d = count_q - (TAG_W+1)'(1);
            default: count_d = count_q;
        endcase

        // Flush throws away all speculative writers, exactly like reset.
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_d[i]   = 1'b0;
                done_d[i]   = 1'b0;
                is_msr_d[i] = 1'b0;
                nzcv_d[i]   = 4'b0000;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]   <= 1'b0;
                done_q[i]   <= 1'b0;
                is_msr_q[i] <= 1'b0;
                nzcv_q[i]   <= 4'b0000;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]   <= busy_d[i];
                done_q[i]   <= done_d[i];
                is_msr_q[i] <= is_msr_d[i];
                nzcv_q[i]   <= nzcv_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_flag_write_sched.sv
module tb_flag_write_sched;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       iss_valid;
  logic       iss_sets_flags;
  logic       iss_is_msr;
  logic       iss_reads_flags;
  logic       iss_stall;
  logic [1:0] iss_tag;
  logic [3:0] rd_nzcv;
  logic [3:0] arch_nzcv;
  logic       alu_wb_valid;
  logic [1:0] alu_wb_tag;
  logic [3:0] alu_wb_nzcv;
  logic       msr_wb_valid;
  logic [1:0] msr_wb_tag;
  logic [3:0] msr_wb_data;
  logic       commit_s;
  logic       commit_msr;
  logic [3:0] commit_nzcv;
  logic [1:0] dbg_head;
  logic [1:0] dbg_tail;
  logic [2:0] dbg_count;

  int n_cmp;
  int n_err;

  flag_write_sched #(.DEPTH(4), .TAG_W(2)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .iss_valid_i       (iss_valid),
    .iss_sets_flags_i  (iss_sets_flags),
    .iss_is_msr_i      (iss_is_msr),
    .iss_reads_flags_i (iss_reads_flags),
    .iss_stall_o       (iss_stall),
    .iss_tag_o         (iss_tag),
    .rd_nzcv_o         (rd_nzcv),
    .arch_nzcv_i       (arch_nzcv),
    .alu_wb_valid_i    (alu_wb_valid),
    .alu_wb_tag_i      (alu_wb_tag),
    .alu_wb_nzcv_i     (alu_wb_nzcv),
    .msr_wb_valid_i    (msr_wb_valid),
    .msr_wb_tag_i      (msr_wb_tag),
    .msr_wb_data_i     (msr_wb_data),
    .commit_s_o        (commit_s),
    .commit_msr_o      (commit_msr),
    .commit_nzcv_o     (commit_nzcv),
    .dbg_head_o        (dbg_head),
    .dbg_tail_o        (dbg_tail),
    .dbg_count_o       (dbg_count)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    iss_valid = 1'b0;
    iss_sets_flags = 1'b0;
    iss_is_msr = 1'b0;
    iss_reads_flags = 1'b0;
    alu_wb_valid = 1'b0;
    alu_wb_tag = 2'd0;
    alu_wb_nzcv = 4'd0;
    msr_wb_valid = 1'b0;
    msr_wb_tag = 2'd0;
    msr_wb_data = 4'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic issue_writer(input logic is_msr);
    iss_valid = 1'b1;
    iss_sets_flags = 1'b1;
    iss_is_msr = is_msr;
    iss_reads_flags = 1'b0;
  endtask

  task automatic issue_none();
    iss_valid = 1'b0;
    iss_sets_flags = 1'b0;
    iss_is_msr = 1'b0;
    iss_reads_flags = 1'b0;
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    arch_nzcv = 4'b0011;
    idle_inputs();
    rst = 1'b1;
    cyc();
    settle();
    // ---------------- reset state ----------------
    check("rst_stall", 8'(iss_stall), 8'h01);
    check("rst_commit_s", 8'(commit_s), 8'h00);
    check("rst_commit_msr", 8'(commit_msr), 8'h00);
    check("rst_commit_nzcv", 8'(commit_nzcv), 8'h00);
    check("rst_iss_tag", 8'(iss_tag), 8'h00);
    check("rst_rd_nzcv", 8'(rd_nzcv), 8'h03);
    check("rst_count", 8'(dbg_count), 8'h00);
    rst = 1'b0;
    cyc();

    // ---------------- single ALU writer ----------------
    issue_writer(1'b0);
    settle();
    check("t1_stall", 8'(iss_stall), 8'h00);
    check("t1_tag", 8'(iss_tag), 8'h00);
    cyc();
    issue_none();
    check("t1_count1", 8'(dbg_count), 8'h01);
    alu_wb_valid = 1'b1; alu_wb_tag = 2'd0; alu_wb_nzcv = 4'b0100;
    settle();
    check("t1_no_early_commit", 8'(commit_s), 8'h00);
    cyc();
    alu_wb_valid = 1'b0;
    settle();
    check("t1_commit_s", 8'(commit_s), 8'h01);
    check("t1_commit_msr", 8'(commit_msr), 8'h00);
    check("t1_commit_nzcv", 8'(commit_nzcv), 8'h04);
    cyc();
    check("t1_count0", 8'(dbg_count), 8'h00);
    check("t1_idle_commit", 8'(commit_s), 8'h00);

    // ---------------- out-of-order writeback, in-order commit ----------------
    do_reset();
    issue_writer(1'b0);
    settle();
    check("t2_tag0", 8'(iss_tag), 8'h00);
    cyc();
    issue_writer(1'b1);
    settle();
    check("t2_tag1", 8'(iss_tag), 8'h01);
    cyc();
    issue_none();
    msr_wb_valid = 1'b1; msr_wb_tag = 2'd1; msr_wb_data = 4'b1001;
    settle();
    check("t2_a_no_commit", 8'({commit_s, commit_msr}), 8'h00);
    cyc();
    msr_wb_valid = 1'b0;
    settle();
    check("t2_b_no_commit", 8'({commit_s, commit_msr}), 8'h00);
    cyc();
    alu_wb_valid = 1'b1; alu_wb_tag = 2'd0; alu_wb_nzcv = 4'b0010;
    settle();
    check("t2_c_no_commit", 8'({commit_s, commit_msr}), 8'h00);
    cyc();
    alu_wb_valid = 1'b0;
    settle();
    check("t2_d_commit_s", 8'({commit_s, commit_msr}), 8'h02);
    check("t2_d_nzcv", 8'(commit_nzcv), 8'h02);
    cyc();
    check("t2_e_commit_msr", 8'({commit_s, commit_msr}), 8'h01);
    check("t2_e_nzcv", 8'(commit_nzcv), 8'h09);
    cyc();
    check("t2_count0", 8'(dbg_count), 8'h00);
    check("t2_idle", 8'({commit_s, commit_msr}), 8'h00);

    // ---------------- full buffer stall and tail wrap ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue_writer(1'b0);
      settle();
      check("t3_fill_stall", 8'(iss_stall), 8'h00);
      check("t3_fill_tag", 8'(iss_tag), 8'(i));
      cyc();
    end
    check("t3_count4", 8'(dbg_count), 8'h04);
    check("t3_full_stall", 8'(iss_stall), 8'h01);
    alu_wb_valid = 1'b1; alu_wb_tag = 2'd0; alu_wb_nzcv = 4'b0001;
    cyc();
    alu_wb_valid = 1'b0;
    settle();
    check("t3_stall_during_commit", 8'(iss_stall), 8'h01);
    check("t3_commit_s", 8'(commit_s), 8'h01);
    check("t3_count_still4", 8'(dbg_count), 8'h04);
    cyc();
    check("t3_count3", 8'(dbg_count), 8'h03);
    check("t3_stall_released", 8'(iss_stall), 8'h00);
    check("t3_wrap_tag", 8'(iss_tag), 8'h00);
    cyc();
    issue_none();
    check("t3_refull", 8'(dbg_count), 8'h04);
    check("t3_tail_wrapped", 8'(dbg_tail), 8'h01);
    check("t3_head", 8'(dbg_head), 8'h01);

    // ---------------- reader stall and forwarding ----------------
    do_reset();
    issue_writer(1'b0);
    cyc();
    iss_valid = 1'b1; iss_sets_flags = 1'b0; iss_is_msr = 1'b0; iss_reads_flags = 1'b1;
    alu_wb_valid = 1'b1; alu_wb_tag = 2'd0; alu_wb_nzcv = 4'b1000;
    settle();
    check("t4_reader_stall", 8'(iss_stall), 8'h01);
    cyc();
    alu_wb_valid = 1'b0;
    settle();
    check("t4_reader_go", 8'(iss_stall), 8'h00);
    check("t4_forward", 8'(rd_nzcv), 8'h08);
    check("t4_commit_same", 8'(commit_s), 8'h01);
    cyc();
    issue_none();
    check("t4_after_commit_arch", 8'(rd_nzcv), 8'h03);

    // ---------------- flush ----------------
    do_reset();
    arch_nzcv = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      issue_writer(1'b0);
      cyc();
    end
    issue_none();
    alu_wb_valid = 1'b1; alu_wb_tag = 2'd0; alu_wb_nzcv = 4'b0101;
    cyc();
    alu_wb_valid = 1'b0;
    flush = 1'b1;
    settle();
    check("t5_flush_no_commit", 8'({commit_s, commit_msr}), 8'h00);
    check("t5_flush_stall", 8'(iss_stall), 8'h01);
    cyc();
    flush = 1'b0;
    check("t5_count0", 8'(dbg_count), 8'h00);
    check("t5_rd_arch", 8'(rd_nzcv), 8'h06);
    alu_wb_valid = 1'b1; alu_wb_tag = 2'd1; alu_wb_nzcv = 4'b1111;
    cyc();
    alu_wb_valid = 1'b0;
    settle();
    check("t5_stale_wb_count", 8'(dbg_count), 8'h00);
    check("t5_stale_wb_commit", 8'({commit_s, commit_msr}), 8'h00);
    check("t5_stale_wb_rd", 8'(rd_nzcv), 8'h06);

    // ---------------- simultaneous allocate/commit, dual writeback ----------------
    do_reset();
    issue_writer(1'b0);
    cyc();
    alu_wb_valid = 1'b1; alu_wb_tag = 2'd0; alu_wb_nzcv = 4'b0001;
    cyc();
    alu_wb_valid = 1'b0;
    check("t6_count2", 8'(dbg_count), 8'h02);
    settle();
    check("t6_commit_s", 8'(commit_s), 8'h01);
    check("t6_alloc_ok", 8'(iss_stall), 8'h00);
    check("t6_tag2", 8'(iss_tag), 8'h02);
    cyc();
    check("t6_count_stays2", 8'(dbg_count), 8'h02);
    check("t6_head1", 8'(dbg_head), 8'h01);
    check("t6_tail3", 8'(dbg_tail), 8'h03);
    issue_writer(1'b1);
    settle();
    check("t6_tag3", 8'(iss_tag), 8'h03);
    cyc();
    issue_none();
    alu_wb_valid = 1'b1; alu_wb_tag = 2'd2; alu_wb_nzcv = 4'b1100;
    msr_wb_valid = 1'b1; msr_wb_tag = 2'd3; msr_wb_data = 4'b1010;
    cyc();
    alu_wb_valid = 1'b0;
    msr_wb_valid = 1'b0;
    iss_valid = 1'b1; iss_reads_flags = 1'b1;
    settle();
    check("t6_slot1_blocks", 8'({commit_s, commit_msr}), 8'h00);
    check("t6_reader_ready", 8'(iss_stall), 8'h00);
    check("t6_fwd_tag3", 8'(rd_nzcv), 8'h0a);
    issue_none();
    alu_wb_valid = 1'b1; alu_wb_tag = 2'd1; alu_wb_nzcv = 4'b0111;
    cyc();
    alu_wb_valid = 1'b0;
    settle();
    check("t6_c1", 8'({commit_s, commit_msr, commit_nzcv}), 8'h27);
    cyc();
    check("t6_c2", 8'({commit_s, commit_msr, commit_nzcv}), 8'h2c);
    cyc();
    check("t6_c3", 8'({commit_s, commit_msr, commit_nzcv}), 8'h1a);
    cyc();
    check("t6_empty", 8'(dbg_count), 8'h00);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flag_write_sched.md
Name: flag_write_sched

Overview:
- In-order scheduler for the NZCV status-flag register in the dynamically scheduled pipeline.
- Allocates an ordered slot for every flag-writing instruction at issue: ALU with S set, or MSR.
- Accepts out-of-order flag writebacks, then commits them to the flag register strictly in program order, one per cycle.
- Stalls or forwards for conditional instructions that read flags; pipeline flush (branch mispredict) discards all speculative flag writes.

Parameters:
- DEPTH, 4, number of in-flight flag-writer slots (power of 2, >=2).
- TAG_W, 2, slot tag width = log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all in-flight slots.
- iss_valid  in  1  instruction presented at issue.
- iss_sets_flags  in  1  issuing instruction writes flags.
- iss_is_msr  in  1  flag writer is MSR (else ALU S-form).
- iss_reads_flags  in  1  issuing instruction is conditional / reads flags.
- iss_stall  out  1  hold issue this cycle.
- iss_tag  out  TAG_W  slot tag given to the issuing writer (= tail).
- rd_nzcv  out  4  flags seen by the issuing reader, {N,Z,C,V}.
- arch_nzcv  in  4  current flag-register outputs {N,Z,C,V}.
- alu_wb_valid  in  1  ALU flag writeback.
- alu_wb_tag  in  TAG_W  slot for ALU writeback.
- alu_wb_nzcv  in  4  ALU result flags.
- msr_wb_valid  in  1  MSR writeback.
- msr_wb_tag  in  TAG_W  slot for MSR writeback.
- msr_wb_data  in  4  MSR operand bits [3:0] = {N,Z,C,V}.
- commit_s  out  1  drives the flag register's S-update input.
- commit_msr  out  1  drives the flag register's MSR-update input.
- commit_nzcv  out  4  value for the flag register (flag inputs and Rm[3:0]).

Behaviour:
- State per slot: busy, done, is_msr, nzcv[3:0]. Global state: head, tail (TAG_W, wrap modulo DEPTH) and count (0..DEPTH).
- Reset (rst=1 at edge): all slots busy=0, done=0, nzcv=0; head=tail=count=0.
- Reset output values: commit_s=0, commit_msr=0, commit_nzcv=0, iss_stall=1, iss_tag=0, rd_nzcv=arch_nzcv.
- flags_ready = (count==0) | slot[tail-1].done.
- iss_stall (combinational) = rst | flush | (iss_valid & ((iss_sets_flags & count==DEPTH) | (iss_reads_flags & !flags_ready))).
- A full-buffer stall uses the current count; a commit in the same cycle does not release it.
- Allocation when iss_valid & iss_sets_flags & !iss_stall:
  - slot[tail] set to busy=1, done=0, is_msr=iss_is_msr; tail++ at the edge.
  - iss_tag = tail, valid in the same cycle.
- Forwarding: rd_nzcv = (count==0) ? arch_nzcv : slot[tail-1].nzcv. This is combinational and always reflects the youngest writer.
- An instruction that both reads and sets flags sees the state before its own allocation.
- Writeback: a valid writeback to a busy, not-done slot sets done=1 and nzcv at the edge.
  - ALU and MSR writebacks to different tags in the same cycle are both accepted.
  - Writebacks to a non-busy slot are ignored.
  - The same tag on both ports in the same cycle is illegal; ALU wins.
- Commit (combinational):
  - cv = (count>0) & slot[head].done & !flush & !rst.
  - commit_s = cv & !is_msr; commit_msr = cv & is_msr; commit_nzcv = slot[head].nzcv.
  - When cv=0, commit_nzcv = 0.
  - On cv, at the edge: slot[head] is cleared and head++. The flag register latches at that same edge.
- Latency: a writeback in cycle t commits in cycle t+1 if it is the head slot; otherwise it waits for all older slots. Throughput is one commit per cycle.
- count update: +1 on allocate, -1 on commit; unchanged on simultaneous allocate and commit.
- flush at the edge: identical to reset for all internal state. Commit and allocation are suppressed that cycle. rd_nzcv reverts to arch_nzcv the next cycle.
- Pointer wrap: tail DEPTH-1 -> 0 and head likewise. count==DEPTH with head==tail means full; count==0 means empty.

Test Plan:
- Reset, then issue ALU-S writer -> iss_tag=0, count=1. ALU wb tag0 nzcv=4'b0100 -> next cycle commit_s=1, commit_nzcv=4'b0100, count=0.
- Allocate tags 0 (ALU) and 1 (MSR); MSR wb tag1 data=4'b1001 first, then ALU wb tag0 4'b0010 two cycles later:
  - commit_s with 4'b0010 occurs in cycle after ALU wb.
  - commit_msr with 4'b1001 occurs the following cycle; no commit before that.
- Fill 4 slots with no writebacks, present fifth writer -> iss_stall=1. wb tag0 -> commit, then stall drops and the fifth writer gets iss_tag=0 (wrap).
- One pending writer not done, present conditional reader -> iss_stall=1. Wb nzcv=4'b1000 -> next cycle stall=0, rd_nzcv=4'b1000 before commit completes.
- 3 slots busy, 1 done at head, assert flush -> no commit pulse that cycle, count=0 next cycle, rd_nzcv=arch_nzcv; a later wb to old tag is ignored.
- Simultaneous allocate and commit at count=2 -> count stays 2, head and tail both advance; ALU and MSR writebacks in one cycle to tags 2 and 3 both marked done.
